rgb_stream_packer: RTL and testbench
====================================

// Module: rgb_stream_packer
// PURPOSE
//  Downstream neighbour of pixel_generator: accepts one 24-bit RGB pixel per handshake and packs
//  4 pixels into 3 x 32-bit AXI4-Stream words for the video DMA / VDMA.
//  Carries frame/line framing: sof -> tuser on the first word of a frame; eol -> tlast on the
//  last word of a line. A small output FIFO absorbs backpressure from out_stream_tready.
// PARAMETERS
//  FIFO_DEPTH   4   output word FIFO entries; must be >= 3, power of two
// PORTS
//  aclk               in   1   single clock for the whole block
//  areset             in   1   reset: synchronous, active-high
//  r, g, b            in   8   pixel colour components; pixel P = {r,g,b}
//  valid              in   1   pixel present on r/g/b/sof/eol
//  sof                in   1   pixel is the first of a frame (x==0,y==0)
//  eol                in   1   pixel is the last of a line
//  in_stream_ready    out  1   block accepts the pixel this cycle
//  out_stream_tdata   out  32  packed pixel bytes
//  out_stream_tkeep   out  4   constant 4'hF
//  out_stream_tlast   out  1   last word of line
//  out_stream_tuser   out  1   first word of frame
//  out_stream_tvalid  out  1   word valid
//  out_stream_tready  in   1   downstream accepts word
//  misalign_err       out  1   sticky: sof seen with phase != 0
// BEHAVIOUR
//  - Pixel accepted when valid && in_stream_ready. Word transferred when tvalid && tready.
//  - in_stream_ready = !areset && (fifo_count <= FIFO_DEPTH-2), so room for 2 pushes always exists.
//  - phase[1:0] counts accepted pixels mod 4; resid[23:0] holds carried bytes.
//    phase0: resid <= P, no push.          phase1: push {P[7:0],  resid[23:0]}, resid <= P[23:8].
//    phase2: push {P[15:0], resid[15:0]}, resid <= P[23:16].
//    phase3: push {P[23:0], resid[7:0]}.
//  - eol flush: phase0+eol pushes {8'h00,P}. phase1+eol pushes normal word, then {16'h0,P[23:8]}
//    in the same cycle (dual push). phase2+eol pushes normal word, then {24'h0,P[23:16]}.
//    phase3+eol pushes normal word only. tlast=1 on the final word pushed. phase <= 0 after eol.
//  - sof: the first word pushed at or after the sof pixel carries tuser=1; only that word does.
//    If sof arrives at phase != 0: drop resid, set misalign_err, treat the pixel as phase0.
//  - Latency: word visible on tdata the cycle after the pixel completing it is accepted (FIFO
//    empty, tready high). Sustained 1 pixel/cycle with tready high; 3 words per 4 pixels.
//  - FIFO: simultaneous push(es) and pop in one cycle allowed; count updates by pushes-pop.
//    tdata/tlast/tuser hold stable while tvalid && !tready.
//  - Reset (any cycle, incl. mid-line or mid-stall): FIFO emptied, phase=0, resid=0, sof pending
//    cleared, misalign_err=0. Outputs: tvalid=0, tdata=0, tlast=0, tuser=0, tkeep=4'hF,
//    in_stream_ready=0.
//  - Arithmetic: no math beyond byte slicing; pointers wrap mod FIFO_DEPTH; count width clog2+1.
// STRUCTURE
//  - pixel_defs.vh: PIXEL_W=24, WORD_W=32, PIX_PER_GROUP=4, X_SIZE=640, Y_SIZE=480.
//  - Sub-module word_fifo: sync FIFO, width 34 ({tuser,tlast,tdata}), up to 2 pushes + 1 pop/cycle,
//    exposes count. Packer FSM (phase/resid/sof-pending) lives in rgb_stream_packer.
// TESTING
//  1 P0..P3=0x112233,0x445566,0x778899,0xAABBCC, tready=1 -> words 0x66112233, 0x88994455,
//    0xAABBCC77; tuser=tlast=0.
//  2 640-pixel line, sof on pixel 0, eol on 639 -> exactly 480 words; tuser only on word 0;
//    tlast only on word 479.
//  3 P0=0x112233, P1=0x445566 with eol -> 0x66112233 (tlast=0), 0x00004455 (tlast=1); next
//    pixel starts phase 0.
//  4 tready low for 10 cycles during a line -> in_stream_ready falls at count >= FIFO_DEPTH-1;
//    held word stable; after release, output equals no-stall reference stream.
//  5 sof on the 3rd pixel of a group -> misalign_err=1; resid dropped; next word built from the
//    sof pixel carries tuser=1.
//  6 areset 1 cycle mid-line with FIFO holding 2 words -> tvalid=0 next cycle, FIFO empty,
//    misalign_err=0; new frame packs correctly.

Source files
------------

// File: rtl/rgb_stream_packer_pkg.sv
// rgb_stream_packer_pkg: shared pixel/word widths, packer phase type and FIFO word record
package rgb_stream_packer_pkg;
  localparam int PIXEL_W = 24;
  localparam int WORD_W = 32;
  localparam int PIX_PER_GROUP = 4;
  localparam int X_SIZE = 640;
  localparam int Y_SIZE = 480;
  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;
  typedef struct packed {
    logic              tuser;
    logic              tlast;
    logic [WORD_W-1:0] tdata;
  } word_t;
endpackage

// File: rtl/rgb_stream_packer_word_fifo.sv
// rgb_stream_packer_word_fifo: sync FIFO of stream words, up to two pushes and one pop per cycle
module rgb_stream_packer_word_fifo
  import rgb_stream_packer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push0_i,
  input  logic                   push1_i,
  input  word_t                  din0_i,
  input  word_t                  din1_i,
  input  logic                   pop_i,
  output word_t                  dout_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  word_t mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic do_pop;
  assign valid_o = count_q != '0;
  assign do_pop = pop_i && valid_o;
  assign dout_o = valid_o ? mem_q[rptr_q] : '0;
  assign count_o = count_q;
  // push1 is only ever issued together with push0, so it lands one slot after it
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      if (push0_i) mem_q[wptr_q] <= din0_i;
      if (push1_i) mem_q[wptr_q + AW'(1)] <= din1_i;
      wptr_q <= wptr_q + AW'(push0_i) + AW'(push1_i);
      rptr_q <= rptr_q + AW'(do_pop);
      count_q <= count_q + CW'(push0_i) + CW'(push1_i) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/rgb_stream_packer.sv
// rgb_stream_packer: packs 24-bit RGB pixels into 32-bit AXI4-Stream words with sof/eol framing
module rgb_stream_packer
  import rgb_stream_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [7:0]        r,
  input  logic [7:0]        g,
  input  logic [7:0]        b,
  input  logic              valid,
  input  logic              sof,
  input  logic              eol,
  output logic              in_stream_ready,
  output logic [WORD_W-1:0] out_stream_tdata,
  output logic [3:0]        out_stream_tkeep,
  output logic              out_stream_tlast,
  output logic              out_stream_tuser,
  output logic              out_stream_tvalid,
  input  logic              out_stream_tready,
  output logic              misalign_err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  phase_t phase_q, phase_d, ph;
  logic [PIXEL_W-1:0] p, resid_q, resid_d;
  logic pend_q, pend_d, err_q, err_d, acc, push0, push1;
  word_t w0, w1, head;
  logic [CW-1:0] count;
  assign p = {r, g, b};
  assign in_stream_ready = !areset && count <= CW'(FIFO_DEPTH - 2);
  assign acc = valid && in_stream_ready;
  // a sof pixel always restarts the group, discarding any carried bytes
  assign ph = sof ? PH0 : phase_q;
  always_ff @(posedge aclk) begin
    if (areset) begin
      phase_q <= PH0;
      resid_q <= '0;
      pend_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      resid_q <= resid_d;
      pend_q <= pend_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    phase_d = acc ? (eol ? PH0 : phase_t'(ph + 2'd1)) : phase_q;
    resid_d = !acc ? resid_q : ph == PH0 ? p : ph == PH1 ? {8'h0, p[23:8]} : {16'h0, p[23:16]};
    pend_d = !push0 && (pend_q || (acc && sof));
    err_d = err_q || (acc && sof && phase_q != PH0);
  end
  always_comb begin
    push0 = acc && (ph != PH0 || eol);
    push1 = acc && eol && (ph == PH1 || ph == PH2);
    w0 = '{tuser: pend_q || sof, tlast: eol && !push1,
           tdata: ph == PH0 ? {8'h0, p} : ph == PH1 ? {p[7:0], resid_q} :
                  ph == PH2 ? {p[15:0], resid_q[15:0]} : {p, resid_q[7:0]}};
    w1 = '{tuser: 1'b0, tlast: 1'b1, tdata: ph == PH1 ? {16'h0, p[23:8]} : {24'h0, p[23:16]}};
  end
  rgb_stream_packer_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .push0_i (push0),
    .push1_i (push1),
    .din0_i  (w0),
    .din1_i  (w1),
    .pop_i   (out_stream_tready),
    .dout_o  (head),
    .valid_o (out_stream_tvalid),
    .count_o (count)
  );
  assign out_stream_tdata = head.tdata;
  assign out_stream_tlast = head.tlast;
  assign out_stream_tuser = head.tuser;
  assign out_stream_tkeep = 4'hF;
  assign misalign_err = err_q;
endmodule

// File: tb/tb_rgb_stream_packer.sv
// tb_rgb_stream_packer: directed table plus framing, stall and reset sequences for rgb_stream_packer
module tb_rgb_stream_packer;
  import rgb_stream_packer_pkg::*;
  logic aclk = 1'b0, areset = 1'b1;
  logic [7:0] r = '0, g = '0, b = '0;
  logic valid = 1'b0, sof = 1'b0, eol = 1'b0, tready = 1'b1;
  logic in_stream_ready, tlast, tuser, tvalid, misalign_err;
  logic [31:0] tdata;
  logic [3:0] tkeep;
  int checks = 0, failures = 0;
  logic [33:0] got[$], exp_q[$];
  logic [7:0] mb[$];
  bit mpend = 0;

  typedef struct {
    logic [23:0] p;
    logic s, e;
    int n;
    logic [33:0] w0, w1;
    logic err;
  } vec_t;
  vec_t tbl[$];

  rgb_stream_packer #(.FIFO_DEPTH(4)) dut (
    .aclk(aclk), .areset(areset), .r(r), .g(g), .b(b), .valid(valid), .sof(sof), .eol(eol),
    .in_stream_ready(in_stream_ready), .out_stream_tdata(tdata), .out_stream_tkeep(tkeep),
    .out_stream_tlast(tlast), .out_stream_tuser(tuser), .out_stream_tvalid(tvalid),
    .out_stream_tready(tready), .misalign_err(misalign_err)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) if (!areset && tvalid && tready) got.push_back({tuser, tlast, tdata});

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  // byte-queue reference: bytes enter LSB first, eol pads the open word with zeros
  task automatic model_pix(logic [23:0] p, logic s, logic e);
    logic [33:0] t;
    if (s) begin
      mb.delete();
      mpend = 1;
    end
    mb.push_back(p[7:0]);
    mb.push_back(p[15:8]);
    mb.push_back(p[23:16]);
    if (e) while (mb.size() % 4 != 0) mb.push_back(8'h00);
    while (mb.size() >= 4) begin
      exp_q.push_back({mpend, 1'b0, mb[3], mb[2], mb[1], mb[0]});
      mpend = 0;
      repeat (4) void'(mb.pop_front());
    end
    if (e) begin
      t = exp_q.pop_back();
      t[32] = 1'b1;
      exp_q.push_back(t);
    end
  endtask

  task automatic send(logic [23:0] p, logic s, logic e);
    bit acc;
    int n = 0;
    {r, g, b} = p;
    sof = s;
    eol = e;
    valid = 1'b1;
    do begin
      @(negedge aclk);
      acc = in_stream_ready;
      @(posedge aclk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", 0, 1);
    valid = 1'b0;
    sof = 1'b0;
    eol = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (tvalid && n < 200) begin
      @(posedge aclk);
      #1;
      n++;
    end
    if (n >= 200) check("drain_timeout", 0, 1);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic compare_streams(string name);
    check({name, "_words"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_w%0d", name, i), got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int users, lasts;
    logic [33:0] held;
    bit have, low;
    tbl.push_back('{24'h112233, 0, 0, 0, 34'h0, 34'h0, 0});
    tbl.push_back('{24'h445566, 0, 0, 1, 34'h0_66112233, 34'h0, 0});
    tbl.push_back('{24'h778899, 0, 0, 1, 34'h0_88994455, 34'h0, 0});
    tbl.push_back('{24'hAABBCC, 0, 0, 1, 34'h0_AABBCC77, 34'h0, 0});
    tbl.push_back('{24'h112233, 0, 0, 0, 34'h0, 34'h0, 0});
    tbl.push_back('{24'h445566, 0, 1, 2, 34'h0_66112233, 34'h1_00004455, 0});
    tbl.push_back('{24'h778899, 0, 0, 0, 34'h0, 34'h0, 0});
    tbl.push_back('{24'hAABBCC, 0, 0, 1, 34'h0_CC778899, 34'h0, 0});
    tbl.push_back('{24'hDDEEFF, 0, 1, 2, 34'h0_EEFFAABB, 34'h1_000000DD, 0});
    tbl.push_back('{24'h123456, 0, 1, 1, 34'h1_00123456, 34'h0, 0});
    tbl.push_back('{24'h010203, 1, 0, 0, 34'h0, 34'h0, 0});
    tbl.push_back('{24'h040506, 0, 0, 1, 34'h2_06010203, 34'h0, 0});
    tbl.push_back('{24'h070809, 0, 0, 1, 34'h0_08090405, 34'h0, 0});
    tbl.push_back('{24'h0A0B0C, 0, 1, 1, 34'h1_0A0B0C07, 34'h0, 0});
    tbl.push_back('{24'h111111, 0, 0, 0, 34'h0, 34'h0, 0});
    tbl.push_back('{24'h222222, 0, 0, 1, 34'h0_22111111, 34'h0, 0});
    tbl.push_back('{24'h333333, 1, 0, 0, 34'h0, 34'h0, 1});
    tbl.push_back('{24'h444444, 0, 0, 1, 34'h2_44333333, 34'h0, 1});
    tbl.push_back('{24'h555555, 0, 0, 1, 34'h0_55554444, 34'h0, 1});
    tbl.push_back('{24'h666666, 0, 1, 1, 34'h1_66666655, 34'h0, 1});

    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_flags", {tlast, tuser}, 0);
    check("rst_tkeep", tkeep, 4'hF);
    check("rst_ready", in_stream_ready, 0);
    check("rst_err", misalign_err, 0);
    areset = 1'b0;
    #1;
    check("ready_after_rst", in_stream_ready, 1);

    // directed table: packing, eol flushes, sof and misaligned sof
    foreach (tbl[i]) begin
      send(tbl[i].p, tbl[i].s, tbl[i].e);
      check($sformatf("tbl_err%0d", i), misalign_err, tbl[i].err);
      if (tbl[i].n > 0) exp_q.push_back(tbl[i].w0);
      if (tbl[i].n > 1) exp_q.push_back(tbl[i].w1);
    end
    drain();
    compare_streams("tbl");

    // reset mid-line with two words parked in the FIFO
    tready = 1'b0;
    send(24'hA1A2A3, 0, 0);
    send(24'hB1B2B3, 0, 0);
    send(24'hC1C2C3, 0, 0);
    check("pre_rst_tvalid", tvalid, 1);
    check("pre_rst_ready", in_stream_ready, 1);
    areset = 1'b1;
    #1;
    check("in_rst_ready", in_stream_ready, 0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    check("post_rst_tvalid", tvalid, 0);
    check("post_rst_tdata", tdata, 0);
    check("post_rst_err", misalign_err, 0);
    #1;
    check("post_rst_ready", in_stream_ready, 1);
    got.delete();
    mb.delete();
    mpend = 0;
    tready = 1'b1;
    send(24'h112233, 1, 0);
    model_pix(24'h112233, 1, 0);
    check("post_rst_nolead", tvalid, 0);
    send(24'h445566, 0, 0);
    model_pix(24'h445566, 0, 0);
    check("latency_word", {tvalid, tuser, tlast, tdata}, {3'b110, 32'h66112233});
    send(24'h778899, 0, 0);
    model_pix(24'h778899, 0, 0);
    send(24'hAABBCC, 0, 1);
    model_pix(24'hAABBCC, 0, 1);
    drain();
    compare_streams("newframe");

    // full 640-pixel line
    for (int i = 0; i < X_SIZE; i++) begin
      send({8'(i), 8'(i >> 8), 8'h5A}, i == 0, i == X_SIZE - 1);
      model_pix({8'(i), 8'(i >> 8), 8'h5A}, i == 0, i == X_SIZE - 1);
    end
    drain();
    users = 0;
    lasts = 0;
    foreach (got[i]) begin
      users += int'(got[i][33]);
      lasts += int'(got[i][32]);
    end
    check("line_words", got.size(), X_SIZE * 3 / PIX_PER_GROUP);
    check("line_users_lasts", {users, lasts}, {32'd1, 32'd1});
    if (got.size() == 480) check("line_ends", {got[0][33], got[479][32]}, 2'b11);
    compare_streams("line");

    // 10-cycle backpressure in the middle of a line
    fork
      for (int i = 0; i < 16; i++) begin
        send({8'hC0 + 8'(i), 8'h3C, 8'(i * 7)}, i == 0, i == 15);
        model_pix({8'hC0 + 8'(i), 8'h3C, 8'(i * 7)}, i == 0, i == 15);
      end
      begin
        repeat (3) @(posedge aclk);
        #1;
        tready = 1'b0;
        have = 0;
        low = 0;
        held = '0;
        for (int k = 0; k < 10; k++) begin
          @(negedge aclk);
          if (have) check($sformatf("stall_hold%0d", k), {tvalid, tuser, tlast, tdata}, {1'b1, held});
          else if (tvalid) begin
            held = {tuser, tlast, tdata};
            have = 1;
          end
          low = low || !in_stream_ready;
        end
        check("stall_seen_word", have, 1);
        check("stall_ready_low", {low, in_stream_ready}, 2'b10);
        @(posedge aclk);
        #1;
        tready = 1'b1;
      end
    join
    drain();
    compare_streams("stall");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
